// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage controller and its MEM/WB register.
// The FSM state encoding and the bubble value live here so both files agree on them.
package mem_stage_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  write_reg;
        logic        align_err;
        logic        bus_err;
    } mem_wb_t;

    // A bubble writes nothing back; the error flags are overlaid by the register.
    localparam mem_wb_t BUBBLE = '0;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/fr_mem_wb.sv
// MEM/WB pipeline register: loads the completed MEM result or a bubble every
// enabled cycle; a bubble can carry a one-cycle alignment or bus error flag.
module fr_mem_wb
    import mem_stage_ctrl_pkg::*;
(
    input  logic    Clk,
    input  logic    Reset,
    input  logic    load_en,
    input  logic    bubble,
    input  logic    align_err,
    input  logic    bus_err,
    input  mem_wb_t d,
    output mem_wb_t q
);

    mem_wb_t bubble_val;

    always_comb begin
        bubble_val           = BUBBLE;
        bubble_val.align_err = align_err;
        bubble_val.bus_err   = bus_err;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= BUBBLE;
        end else if (bubble) begin
            q <= bubble_val;
        end else if (load_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: issues one req/ack data-memory access per aligned load/store,
// stalls upstream while waiting, aborts after TIMEOUT cycles, and fills MEM/WB.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        DReq,
    output logic        DWe,
    output logic [31:0] DAddr,
    output logic [31:0] DWData,
    input  logic        DAck,
    input  logic [31:0] DRData,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUResultW,
    output logic [4:0]  WriteRegW,
    output logic        AlignErrW,
    output logic        BusErrW
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;

    logic    is_load;
    logic    memop;
    logic    aligned;
    logic    in_idle;
    logic    in_wait;
    logic    abort;
    logic    align_bubble;
    logic    bus_bubble;
    logic    wb_bubble;
    mem_wb_t wb_next;
    mem_wb_t wb_reg;

    // A store wins when both MemWriteM and MemtoRegM are set.
    assign is_load = MemtoRegM & ~MemWriteM;
    assign memop   = MemtoRegM | MemWriteM;
    assign aligned = is_aligned(ALUResultM);
    assign in_idle = (state_reg == ST_IDLE);
    assign in_wait = (state_reg == ST_WAIT);
    assign abort   = in_wait & (wait_cnt_reg == TIMEOUT_CNT);

    // Gating with Reset drops the request immediately, so a late ack cannot land.
    assign DReq   = ~Reset & ((in_idle & memop & aligned) | in_wait);
    assign DWe    = MemWriteM & DReq;
    assign DAddr  = DReq ? ALUResultM : 32'h0;
    assign DWData = DReq ? WriteDataM : 32'h0;
    assign StallM = DReq & ~DAck & ~abort;

    assign align_bubble = ~Reset & in_idle & memop & ~aligned;
    assign bus_bubble   = DReq & abort & ~DAck;
    assign wb_bubble    = StallM | align_bubble | bus_bubble;

    always_comb begin
        wb_next            = BUBBLE;
        wb_next.reg_write  = RegWriteM;
        wb_next.mem_to_reg = is_load;
        wb_next.read_data  = is_load ? DRData : 32'h0;
        wb_next.alu_result = ALUResultM;
        wb_next.write_reg  = WriteRegM;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (memop & aligned & ~DAck) begin
                        state_reg    <= ST_WAIT;
                        wait_cnt_reg <= CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (DAck | abort) begin
                        state_reg    <= ST_IDLE;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

    fr_mem_wb u_mem_wb (
        .Clk       (Clk),
        .Reset     (Reset),
        .load_en   (1'b1),
        .bubble    (wb_bubble),
        .align_err (align_bubble),
        .bus_err   (bus_bubble),
        .d         (wb_next),
        .q         (wb_reg)
    );

    assign RegWriteW  = wb_reg.reg_write;
    assign MemtoRegW  = wb_reg.mem_to_reg;
    assign ReadDataW  = wb_reg.read_data;
    assign ALUResultW = wb_reg.alu_result;
    assign WriteRegW  = wb_reg.write_reg;
    assign AlignErrW  = wb_reg.align_err;
    assign BusErrW    = wb_reg.bus_err;

endmodule
